// File: rtl/np_pkg.sv
// np_pkg: shared stream constants and state encoding
// for the multicore ingress dispatcher.
package np_pkg;

    localparam int NP_DATA_WIDTH = 64;
    localparam int NP_CTRL_WIDTH = 8;

    localparam logic [7:0] CTRL_MODULE_HDR = 8'hFF;
    localparam logic [7:0] CTRL_PAYLOAD    = 8'h00;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/np_rr_arbiter.sv
// np_rr_arbiter: combinational round-robin pick, searching
// upward from last+1 modulo N.
module np_rr_arbiter
    import np_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   last,
    input  logic         grant_en,
    output logic [2:0]   gnt_idx,
    output logic         gnt_valid
);

    logic [7:0] req_w;
    logic [3:0] cand;

    always_comb begin
        req_w     = 8'(req);
        cand      = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, last} + 4'(i);
            if (cand >= 4'(N)) begin
                cand = cand - 4'(N);
            end
            if (grant_en && !gnt_valid && req_w[cand[2:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[2:0];
            end
        end
    end

endmodule

// File: rtl/np_dispatch.sv
// np_dispatch: forwards each whole packet of one stream to a
// single core, chosen round-robin among enabled, ready cores.
module np_dispatch
    import np_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int DATA_WIDTH = NP_DATA_WIDTH,
    parameter int CTRL_WIDTH = NP_CTRL_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [NUM_CORES-1:0]  out_wr,
    input  logic [NUM_CORES-1:0]  core_rdy,
    input  logic [NUM_CORES-1:0]  core_en,
    output logic [2:0]            cur_core,
    output logic                  busy,
    output logic [31:0]           pkt_count,
    output logic                  proto_err
);

    localparam logic [NUM_CORES-1:0] ONE = NUM_CORES'(1);

    state_t     state;
    state_t     state_nx;
    logic [2:0] last_grant;
    logic       seen_payload;
    logic [7:0] rdy_w;
    logic       accept;
    logic       is_pay;
    logic       is_hdr;
    logic       eop;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    np_rr_arbiter #(
        .N(NUM_CORES)
    ) u_arb (
        .req      (core_en & core_rdy),
        .last     (last_grant),
        .grant_en (state == IDLE),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    assign rdy_w  = 8'(core_rdy);
    assign in_rdy = (state == XFER) && rdy_w[cur_core];
    assign accept = in_wr && in_rdy;
    assign is_pay = (in_ctrl == CTRL_WIDTH'(CTRL_PAYLOAD));
    assign is_hdr = (in_ctrl == CTRL_WIDTH'(CTRL_MODULE_HDR));
    // a marker ctrl only ends the packet once payload has been seen
    assign eop    = accept && !is_pay && !is_hdr && seen_payload;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (eop) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data     <= '0;
            out_ctrl     <= '0;
            out_wr       <= '0;
            cur_core     <= '0;
            busy         <= 1'b0;
            pkt_count    <= '0;
            proto_err    <= 1'b0;
            seen_payload <= 1'b0;
            last_grant   <= 3'(NUM_CORES - 1);
        end else begin
            out_wr <= accept ? (ONE << cur_core) : '0;
            if (accept) begin
                out_data <= in_data;
                out_ctrl <= in_ctrl;
                if (is_pay) begin
                    seen_payload <= 1'b1;
                end
            end
            if (state == IDLE && gnt_valid) begin
                cur_core     <= gnt_idx;
                busy         <= 1'b1;
                seen_payload <= 1'b0;
            end
            if (eop) begin
                last_grant <= cur_core;
                pkt_count  <= pkt_count + 32'd1;
                busy       <= 1'b0;
            end
            if (in_wr && !in_rdy) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_np_dispatch.sv
// tb_np_dispatch: directed packet vectors plus hand-written
// stall, protocol-error and mid-packet reset sequences.
module tb_np_dispatch;
    import np_pkg::*;

    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   in_data;
    logic [7:0]    in_ctrl;
    logic          in_wr;
    logic          in_rdy;
    logic [63:0]   out_data;
    logic [7:0]    out_ctrl;
    logic [NC-1:0] out_wr;
    logic [NC-1:0] core_rdy;
    logic [NC-1:0] core_en;
    logic [2:0]    cur_core;
    logic          busy;
    logic [31:0]   pkt_count;
    logic          proto_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  rdy;
        int          nw;
        int          core;
        int          idle;
        logic [31:0] cnt;
    } vec_t;

    np_dispatch #(
        .NUM_CORES(NC)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_wr    (in_wr),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_wr   (out_wr),
        .core_rdy (core_rdy),
        .core_en  (core_en),
        .cur_core (cur_core),
        .busy     (busy),
        .pkt_count(pkt_count),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] wdata(int pid, int w, int nw);
        if (w == 0) return 64'h0000000e0004006a;
        if (w == nw - 1) return 64'h3e3f3f3f3f3f3f3f;
        return {16'ha5a5, 16'(pid), 32'(w)};
    endfunction

    function automatic logic [7:0] wctrl(int w, int nw);
        if (w == 0) return 8'hff;
        if (w == nw - 1) return 8'h02;
        return 8'h00;
    endfunction

    // called at posedge+1; returns at posedge+1 after the last word
    task automatic send_pkt(input int exp_core, input int nw,
                            input int pid, input int stall_at,
                            input int abort_at, output int idle);
        idle = 0;
        while (in_rdy !== 1'b1 && idle < 20) begin
            @(posedge clk);
            #1;
            idle++;
        end
        chk("grant_in_rdy", 64'(in_rdy), 64'd1);
        chk("grant_core", 64'(cur_core), 64'(exp_core));
        chk("grant_busy", 64'(busy), 64'd1);
        for (int w = 0; w < nw; w++) begin
            if (w == abort_at) return;
            if (w == stall_at) begin
                core_rdy[exp_core] = 1'b0;
                #1;
                chk("stall_in_rdy", 64'(in_rdy), 64'd0);
                for (int s = 0; s < 3; s++) begin
                    @(posedge clk);
                    #1;
                    chk("stall_out_wr", 64'(out_wr), 64'd0);
                    if (s < 2) chk("stall_in_rdy", 64'(in_rdy), 64'd0);
                end
                core_rdy[exp_core] = 1'b1;
            end
            in_wr   = 1'b1;
            in_data = wdata(pid, w, nw);
            in_ctrl = wctrl(w, nw);
            #1;
            chk("word_in_rdy", 64'(in_rdy), 64'd1);
            @(posedge clk);
            #1;
            in_wr = 1'b0;
            chk("out_wr", 64'(out_wr), 64'(4'(1) << exp_core));
            chk("out_data", out_data, wdata(pid, w, nw));
            chk("out_ctrl", 64'(out_ctrl), 64'(wctrl(w, nw)));
        end
        chk("eop_busy", 64'(busy), 64'd0);
        chk("eop_in_rdy", 64'(in_rdy), 64'd0);
    endtask

    task automatic chk_reset_state();
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        chk("rst_out_wr", 64'(out_wr), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cur_core", 64'(cur_core), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int   idle;

        vecs[0] = '{4'hf, 4'hf, 16, 0, -1, 32'd1};
        vecs[1] = '{4'hf, 4'hf, 3,  1, 1,  32'd2};
        vecs[2] = '{4'hf, 4'hf, 3,  2, 1,  32'd3};
        vecs[3] = '{4'hf, 4'hf, 3,  3, 1,  32'd4};
        vecs[4] = '{4'hf, 4'hf, 3,  0, 1,  32'd5};
        vecs[5] = '{4'ha, 4'h7, 3,  1, 1,  32'd6};
        vecs[6] = '{4'ha, 4'h7, 3,  1, 1,  32'd7};
        vecs[7] = '{4'ha, 4'hf, 3,  3, 1,  32'd8};
        vecs[8] = '{4'ha, 4'hf, 3,  1, 1,  32'd9};

        rst_n    = 1'b0;
        in_wr    = 1'b0;
        in_data  = '0;
        in_ctrl  = '0;
        core_rdy = '1;
        core_en  = '1;
        #12;
        chk_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            core_en  = vecs[i].en;
            core_rdy = vecs[i].rdy;
            send_pkt(vecs[i].core, vecs[i].nw, i, -1, -1, idle);
            if (vecs[i].idle >= 0) begin
                chk("rr_idle", 64'(idle), 64'(vecs[i].idle));
            end
            chk("pkt_count", 64'(pkt_count), 64'(vecs[i].cnt));
        end

        core_en  = '1;
        core_rdy = '1;
        send_pkt(2, 16, 20, 5, -1, idle);
        chk("stall_pkt_count", 64'(pkt_count), 64'd10);

        core_en = '0;
        chk("proto_err_clear", 64'(proto_err), 64'd0);
        @(posedge clk);
        #1;
        in_wr   = 1'b1;
        in_data = 64'hdeadbeefdeadbeef;
        in_ctrl = 8'h00;
        #1;
        chk("proto_in_rdy", 64'(in_rdy), 64'd0);
        @(posedge clk);
        #1;
        in_wr = 1'b0;
        chk("proto_out_wr", 64'(out_wr), 64'd0);
        chk("proto_err_set", 64'(proto_err), 64'd1);
        chk("proto_busy", 64'(busy), 64'd0);
        core_en = '1;
        send_pkt(3, 3, 30, -1, -1, idle);
        chk("proto_err_sticky", 64'(proto_err), 64'd1);
        chk("proto_pkt_count", 64'(pkt_count), 64'd11);
        send_pkt(0, 3, 31, -1, -1, idle);
        chk("pre_abort_count", 64'(pkt_count), 64'd12);

        send_pkt(1, 16, 40, -1, 8, idle);
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_pkt(0, 16, 41, -1, -1, idle);
        chk("post_rst_count", 64'(pkt_count), 64'd1);
        chk("post_rst_proto", 64'(proto_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
